branch_issue_queue: RTL
=======================

Name: branch_issue_queue

Overview:
- In-order issue queue and scheduler for the branch unit.
- Buffers decoded conditional branches until both source operands are available, either at insert or by snooping the common data bus (CDB).
- Issues the oldest branch to the branch unit via its ops_valid/ops_ready handshake, with at most one branch in flight.
- Pairs each branch-unit result with the ROB tag of the issued branch.
- Sits between the issue stage and the branch unit.

Parameters:
- DEPTH, 4, number of queue entries (integer ≥ 2; need not be a power of two).
- TAG_W, 6, width of ROB/CDB tags.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of all queue and in-flight state
- ins_valid_i  in  1  insert request
- ins_ready_o  out  1  queue can accept an insert
- ins_type_i  in  branch_type_t  branch condition
- ins_rs1_ready_i / ins_rs2_ready_i  in  1  operand value is valid at insert
- ins_rs1_tag_i / ins_rs2_tag_i  in  TAG_W  producer tag when the operand is not ready
- ins_rs1_i / ins_rs2_i  in  XLEN  operand value
- ins_imm_i  in  B_IMM  branch immediate
- ins_pred_pc_i / ins_pred_target_i  in  XLEN  predicted PC and target
- ins_pred_taken_i  in  1  predicted direction
- ins_tag_i  in  TAG_W  ROB tag of the branch
- cdb_valid_i  in  1  CDB broadcast valid
- cdb_tag_i  in  TAG_W  CDB tag
- cdb_value_i  in  XLEN  CDB value
- bu_ops_valid_o  out  1  operands valid to the branch unit
- bu_ops_ready_i  in  1  branch unit ready
- bu_rs1_o / bu_rs2_o  out  XLEN  operands
- bu_imm_o  out  B_IMM  immediate
- bu_pred_pc_o / bu_pred_target_o  out  XLEN  predicted PC and target
- bu_pred_taken_o  out  1  predicted direction
- bu_type_o  out  branch_type_t  branch condition
- bu_res_valid_i  in  1  branch unit result valid
- res_valid_o  out  1  result valid for the ROB
- res_tag_o  out  TAG_W  ROB tag of the resolved branch

Behaviour:
- Reset:
  - All entries invalid; head = tail = count = 0; in-flight flag = 0.
  - ins_ready_o = 1, bu_ops_valid_o = 0, res_valid_o = 0.
  - All data outputs = 0.
- Storage:
  - Circular buffer; pointers wrap from DEPTH-1 to 0.
  - count width is $clog2(DEPTH+1).
- Insert:
  - ins_ready_o = (count < DEPTH) and !flush_i. This is combinational and has no same-cycle pop bypass, so a full queue refuses inserts even while it pops.
  - On ins_valid_i && ins_ready_o: write the entry at tail, then tail++ and count++.
- Snoop:
  - Every cycle, each valid entry with a not-ready operand whose tag equals cdb_tag_i while cdb_valid_i is high captures cdb_value_i and marks that operand ready. The capture is visible next cycle.
  - The inserting entry also snoops in its insert cycle: a not-ready operand whose tag matches the CDB is stored as ready.
  - rs1 and rs2 may both match the same broadcast; both capture.
- Issue:
  - bu_ops_valid_o = head valid && head rs1 ready && head rs2 ready && !inflight && !flush_i.
  - bu_* outputs are driven combinationally from the head entry; they are 0 when the queue is empty.
  - Issue is strictly in order: a ready younger entry never bypasses a non-ready head.
  - Fire (bu_ops_valid_o && bu_ops_ready_i): invalidate head, head++, count--, set inflight = 1, latch the head tag.
  - Simultaneous insert and fire: count is unchanged.
- Latency:
  - Insert with both operands ready into an empty, idle queue: bu_ops_valid_o high the next cycle.
  - CDB wake-up of the head: bu_ops_valid_o high the cycle after the broadcast.
- Result:
  - res_valid_o = bu_res_valid_i && inflight && !flush_i; res_tag_o = latched tag.
  - inflight clears on bu_res_valid_i. A new issue is blocked until the cycle after the result.
  - bu_res_valid_i while not in flight is ignored (res_valid_o = 0).
- Flush:
  - Highest priority, synchronous. Clears all valid bits, pointers, count and inflight.
  - In the flush cycle: insert is ignored, bu_ops_valid_o = 0, res_valid_o = 0.
- Asynchronous reset mid-operation returns all state to the reset values immediately.

Decomposition:
- len5_pkg gains:
  - bq_entry_t struct: valid, type, rs1/rs2 {ready, tag, value}, imm, pred_pc, pred_target, pred_taken, tag.
  - BQ_DEPTH default constant.
- No sub-module: per-entry snoop logic is a generate loop; pointer and count logic is inline.

Test Plan:
- Insert BEQ with rs1 = rs2 = 5, both ready, tag 3, bu_ops_ready_i = 1 → bu_ops_valid_o high next cycle with bu_rs1_o = 5. bu_res_valid_i two cycles later → res_valid_o = 1, res_tag_o = 3.
- Insert with rs2 not ready, tag 9; CDB tag 9, value 0x20 two cycles later → issue the cycle after the broadcast with bu_rs2_o = 0x20. A CDB broadcast with tag 8 causes no wake-up.
- Head waits on tag 4 while entry 2 is ready → no issue until CDB tag 4 arrives; then entry 1 issues, then entry 2 issues after entry 1's result.
- Fill 4 entries → ins_ready_o = 0; fire and insert in the same cycle → insert refused, count = 3. Repeat 6 insert/issue rounds → pointers wrap and order is preserved.
- Insert in the same cycle as CDB tag match (tag 7) → operand captured, issue the next cycle.
- flush_i with 3 entries queued and 1 in flight → the next cycle ins_ready_o = 1 and bu_ops_valid_o = 0; a later bu_res_valid_i gives res_valid_o = 0. Async reset mid-fill → reset values are restored.

Source files
------------

// File: rtl/len5_pkg.sv
// Shared types for the LEN5 backend.
// Branch issue queue entry layout and defaults.
package len5_pkg;

  localparam int XLEN     = 64;
  localparam int B_IMM    = 12;
  localparam int BQ_DEPTH = 4;
  localparam int BQ_TAG_W = 6;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5
  } branch_type_t;

  typedef struct packed {
    logic                ready;
    logic [BQ_TAG_W-1:0] tag;
    logic [XLEN-1:0]     value;
  } bq_op_t;

  typedef struct packed {
    logic                valid;
    branch_type_t        br_type;
    bq_op_t              rs1;
    bq_op_t              rs2;
    logic [B_IMM-1:0]    imm;
    logic [XLEN-1:0]     pred_pc;
    logic [XLEN-1:0]     pred_target;
    logic                pred_taken;
    logic [BQ_TAG_W-1:0] tag;
  } bq_entry_t;

endpackage

// File: rtl/branch_issue_queue.sv
// In-order branch issue queue with CDB wake-up.
// One branch in flight; result paired with its ROB tag.
module branch_issue_queue
  import len5_pkg::*;
#(
  parameter int DEPTH = BQ_DEPTH,
  parameter int TAG_W = BQ_TAG_W
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               flush_i,
  input  logic               ins_valid_i,
  output logic               ins_ready_o,
  input  branch_type_t       ins_type_i,
  input  logic               ins_rs1_ready_i,
  input  logic               ins_rs2_ready_i,
  input  logic [TAG_W-1:0]   ins_rs1_tag_i,
  input  logic [TAG_W-1:0]   ins_rs2_tag_i,
  input  logic [XLEN-1:0]    ins_rs1_i,
  input  logic [XLEN-1:0]    ins_rs2_i,
  input  logic [B_IMM-1:0]   ins_imm_i,
  input  logic [XLEN-1:0]    ins_pred_pc_i,
  input  logic [XLEN-1:0]    ins_pred_target_i,
  input  logic               ins_pred_taken_i,
  input  logic [TAG_W-1:0]   ins_tag_i,
  input  logic               cdb_valid_i,
  input  logic [TAG_W-1:0]   cdb_tag_i,
  input  logic [XLEN-1:0]    cdb_value_i,
  output logic               bu_ops_valid_o,
  input  logic               bu_ops_ready_i,
  output logic [XLEN-1:0]    bu_rs1_o,
  output logic [XLEN-1:0]    bu_rs2_o,
  output logic [B_IMM-1:0]   bu_imm_o,
  output logic [XLEN-1:0]    bu_pred_pc_o,
  output logic [XLEN-1:0]    bu_pred_target_o,
  output logic               bu_pred_taken_o,
  output branch_type_t       bu_type_o,
  input  logic               bu_res_valid_i,
  output logic               res_valid_o,
  output logic [TAG_W-1:0]   res_tag_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic                inflight;
  logic [BQ_TAG_W-1:0] tag_q;

  bq_entry_t q [DEPTH];
  bq_entry_t hd;
  bq_entry_t new_e;

  logic cdb1;
  logic cdb2;
  logic ins_fire;
  logic fire;

  function automatic logic [PW-1:0] wrap_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign hd = q[head];

  assign ins_ready_o = (count < CW'(DEPTH)) && !flush_i;
  assign ins_fire    = ins_valid_i && ins_ready_o;

  assign bu_ops_valid_o = hd.valid && hd.rs1.ready
                       && hd.rs2.ready && !inflight
                       && !flush_i;
  assign fire = bu_ops_valid_o && bu_ops_ready_i;

  assign bu_rs1_o         = hd.valid ? hd.rs1.value : '0;
  assign bu_rs2_o         = hd.valid ? hd.rs2.value : '0;
  assign bu_imm_o         = hd.valid ? hd.imm : '0;
  assign bu_pred_pc_o     = hd.valid ? hd.pred_pc : '0;
  assign bu_pred_target_o = hd.valid ? hd.pred_target : '0;
  assign bu_pred_taken_o  = hd.valid && hd.pred_taken;
  assign bu_type_o        = hd.valid ? hd.br_type : BEQ;

  assign res_valid_o = bu_res_valid_i && inflight && !flush_i;
  assign res_tag_o   = TAG_W'(tag_q);

  // The inserting entry snoops the CDB in its own insert cycle
  assign cdb1 = cdb_valid_i && (ins_rs1_tag_i == cdb_tag_i);
  assign cdb2 = cdb_valid_i && (ins_rs2_tag_i == cdb_tag_i);

  always_comb begin
    new_e             = '0;
    new_e.valid       = 1'b1;
    new_e.br_type     = ins_type_i;
    new_e.rs1.ready   = ins_rs1_ready_i || cdb1;
    new_e.rs1.tag     = BQ_TAG_W'(ins_rs1_tag_i);
    new_e.rs1.value   = (!ins_rs1_ready_i && cdb1)
                      ? cdb_value_i : ins_rs1_i;
    new_e.rs2.ready   = ins_rs2_ready_i || cdb2;
    new_e.rs2.tag     = BQ_TAG_W'(ins_rs2_tag_i);
    new_e.rs2.value   = (!ins_rs2_ready_i && cdb2)
                      ? cdb_value_i : ins_rs2_i;
    new_e.imm         = ins_imm_i;
    new_e.pred_pc     = ins_pred_pc_i;
    new_e.pred_target = ins_pred_target_i;
    new_e.pred_taken  = ins_pred_taken_i;
    new_e.tag         = BQ_TAG_W'(ins_tag_i);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    bq_entry_t e;
    logic      wr;
    logic      pop;
    logic      s1;
    logic      s2;

    assign wr  = ins_fire && (tail == PW'(i));
    assign pop = fire && (head == PW'(i));
    assign s1  = e.valid && !e.rs1.ready && cdb_valid_i
              && (e.rs1.tag == BQ_TAG_W'(cdb_tag_i));
    assign s2  = e.valid && !e.rs2.ready && cdb_valid_i
              && (e.rs2.tag == BQ_TAG_W'(cdb_tag_i));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        e <= '0;
      end else if (flush_i) begin
        e.valid <= 1'b0;
      end else if (wr) begin
        e <= new_e;
      end else begin
        if (pop) e.valid <= 1'b0;
        if (s1) begin
          e.rs1.ready <= 1'b1;
          e.rs1.value <= cdb_value_i;
        end
        if (s2) begin
          e.rs2.ready <= 1'b1;
          e.rs2.value <= cdb_value_i;
        end
      end
    end

    assign q[i] = e;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (ins_fire) tail <= wrap_inc(tail);
      if (fire)     head <= wrap_inc(head);
      if (ins_fire && !fire)
        count <= count + CW'(1);
      else if (fire && !ins_fire)
        count <= count - CW'(1);
    end
  end

  // A fire and a stray result in the same cycle: the fire wins
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inflight <= 1'b0;
      tag_q    <= '0;
    end else if (flush_i) begin
      inflight <= 1'b0;
    end else if (fire) begin
      inflight <= 1'b1;
      tag_q    <= hd.tag;
    end else if (bu_res_valid_i) begin
      inflight <= 1'b0;
    end
  end

endmodule
